pix_pack_fifo: RTL and testbench

- Parametrised successor to the fixed 6-to-24 pixel width-conversion buffer and the frame-level output FIFO, merged into one single-clock block.
- Packs RATIO consecutive IN_W-bit ADC samples into one IN_W*RATIO-bit word and buffers the words in a DEPTH-word FIFO.
- Provides programmable high/low watermarks (frame-level flags), flush of a partial word, and sticky overflow/underflow with a drop counter.
- Sits between the imager data capture (already in clk domain) and the host pipe-out read port.

---
 rtl/pix_pack_pkg.sv | 28 ++
 rtl/pix_pack_fifo_if.sv | 43 ++++
 rtl/sync_fifo_ram.sv | 58 +++++
 rtl/pix_pack_fifo.sv | 147 ++++++++++++++
 tb/tb_pix_pack_fifo.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pix_pack_pkg.sv
// pix_pack_pkg: shared constants and helpers for the pixel pack FIFO.
//   clog2     - ceiling log2 for sizing address/index widths
//   slot_off  - bit offset of a sample slot inside a packed word
//   DROP_W    - width of the saturating drop counter
package pix_pack_pkg;

    localparam int DROP_W = 16;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Slot k holds the k-th sample of a word. LSB-first puts slot 0 at the
    // bottom; otherwise slot 0 lands in the most-significant position.
    function automatic int slot_off(input int k, input int ratio, input int in_w,
                                    input bit lsb_first);
        return lsb_first ? k * in_w : (ratio - 1 - k) * in_w;
    endfunction

endpackage

// File: rtl/pix_pack_fifo_if.sv
// pix_pack_fifo_if: sample input, read port, watermarks and status of the
// pixel pack FIFO.
//   master - producer/consumer side: drives in_data/in_val/flush/rd_en and
//            the watermarks, observes data and status
//   slave  - the FIFO itself
interface pix_pack_fifo_if
    import pix_pack_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int RATIO = 4,
    parameter int DEPTH = 1024,
    parameter int AW    = clog2(DEPTH)
);
    logic [IN_W-1:0]       in_data;
    logic                  in_val;
    logic                  flush;
    logic                  rd_en;
    logic [IN_W*RATIO-1:0] dout;
    logic                  dout_val;
    logic                  empty;
    logic                  full;
    logic [AW:0]           level;
    logic [AW:0]           hi_mark;
    logic [AW:0]           lo_mark;
    logic                  prog_full;
    logic                  prog_empty;
    logic                  partial;
    logic                  overflow;
    logic                  underflow;
    logic [DROP_W-1:0]     drop_cnt;

    modport master (
        output in_data, in_val, flush, rd_en, hi_mark, lo_mark,
        input  dout, dout_val, empty, full, level, prog_full, prog_empty,
               partial, overflow, underflow, drop_cnt
    );

    modport slave (
        input  in_data, in_val, flush, rd_en, hi_mark, lo_mark,
        output dout, dout_val, empty, full, level, prog_full, prog_empty,
               partial, overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock dual-port word store with pointers and level.
//   clk, rst  - clock, synchronous active-high reset
//   wr_en     - write wr_data at the write pointer (caller guarantees room,
//               or a same-edge read)
//   rd_en     - pop the oldest word into rd_data (caller guarantees !empty)
//   rd_data   - registered read data, holds between reads
//   level     - stored word count; empty/full derived from it
module sync_fifo_ram #(
    parameter int W     = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // When full, wptr == rptr; a same-edge read still returns the old
    // (oldest) word because the write lands after the read samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr];
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
endmodule

// File: rtl/pix_pack_fifo.sv
// pix_pack_fifo: packs RATIO IN_W-bit samples into one word and buffers the
// words in a DEPTH-word FIFO, with flush of a partial word, watermarks and
// sticky overflow/underflow plus a saturating drop counter.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of pix_pack_fifo_if (samples in, read port,
//              watermarks, status)
module pix_pack_fifo
    import pix_pack_pkg::*;
#(
    parameter int              IN_W      = 6,
    parameter int              RATIO     = 4,
    parameter int              DEPTH     = 1024,
    parameter int              AW        = clog2(DEPTH),
    parameter int              LSB_FIRST = 1,
    parameter logic [IN_W-1:0] PAD       = '0
) (
    input logic             clk,
    input logic             rst,
    pix_pack_fifo_if.slave  bus
);
    localparam int W  = IN_W * RATIO;
    localparam int IW = clog2(RATIO);

    // ---------------- packer ----------------
    logic [IW-1:0]                 idx;
    logic [RATIO-1:0][IN_W-1:0]    slots;
    logic [RATIO-1:0][IN_W-1:0]    slots_n;
    logic [IW:0]                   cnt_n;   // samples held after this edge
    logic                          done;
    logic [W-1:0]                  word_n;
    logic                          wr_pend;
    logic [W-1:0]                  wr_word;

    always_comb begin
        slots_n = slots;
        cnt_n   = {1'b0, idx} + {{IW{1'b0}}, bus.in_val};
        done    = 1'b0;
        if (bus.in_val) slots_n[idx] = bus.in_data;
        // A word completed by the sample itself wins; a flush arriving
        // with it then sees zero held samples and adds nothing.
        if (cnt_n == (IW+1)'(RATIO)) begin
            done = 1'b1;
        end else if (bus.flush && cnt_n != '0) begin
            done = 1'b1;
            for (int k = 0; k < RATIO; k++) begin
                if (k >= int'(cnt_n)) slots_n[k] = PAD;
            end
        end
    end

    always_comb begin
        word_n = '0;
        for (int k = 0; k < RATIO; k++) begin
            word_n[slot_off(k, RATIO, IN_W, LSB_FIRST != 0) +: IN_W] = slots_n[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            slots   <= '0;
            wr_pend <= 1'b0;
            wr_word <= '0;
        end else begin
            wr_pend <= done;
            if (done) begin
                wr_word <= word_n;
                idx     <= '0;
                slots   <= '0;
            end else begin
                idx     <= cnt_n[IW-1:0];
                slots   <= slots_n;
            end
        end
    end

    assign bus.partial = (idx != '0);

    // ---------------- FIFO ----------------
    logic          rd_ok;
    logic          wr_ok;
    logic          drop;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic [W-1:0]  rd_data;

    assign rd_ok = bus.rd_en & ~empty;
    // A full FIFO still takes the word if a read frees a slot on this edge.
    assign wr_ok = wr_pend & (~full | rd_ok);
    assign drop  = wr_pend & ~wr_ok;

    sync_fifo_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_data (wr_word),
        .rd_en   (rd_ok),
        .rd_data (rd_data),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    // ---------------- flags ----------------
    logic              dout_val;
    logic              overflow;
    logic              underflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              prog_full;
    logic              prog_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_val   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_cnt   <= '0;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
        end else begin
            dout_val <= rd_ok;
            if (drop) overflow <= 1'b1;
            if (bus.rd_en && empty) underflow <= 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            // Compared against the level already updated on the previous
            // edge, so the flags trail level by one cycle.
            prog_full  <= (level >= bus.hi_mark);
            prog_empty <= (level <= bus.lo_mark);
        end
    end

    assign bus.dout       = rd_data;
    assign bus.dout_val   = dout_val;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.level      = level;
    assign bus.prog_full  = prog_full;
    assign bus.prog_empty = prog_empty;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;
    assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_pix_pack_fifo.sv
// tb_pix_pack_fifo: directed and randomized checks of pix_pack_fifo against
// a queue-based model of sample packing and word storage.
module tb_pix_pack_fifo;
    localparam int IN_W      = 6;
    localparam int RATIO     = 4;
    localparam int DEPTH     = 64;
    localparam int AW        = 6;
    localparam int W         = IN_W * RATIO;
    localparam int LSB_FIRST = 1;
    localparam int PADV      = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pix_pack_fifo_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .AW(AW)) bus ();

    pix_pack_fifo #(
        .IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .AW(AW),
        .LSB_FIRST(LSB_FIRST), .PAD(IN_W'(PADV))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state
    logic [W-1:0] mq[$];
    int           sq[$];
    int           mdrop = 0;
    logic [W-1:0] last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packing rule: a word forms when RATIO samples are held, or on a flush
    // while some are held (rest padded). Stored if there is room.
    task automatic m_cycle(input bit v, input int d, input bit f);
        logic [W-1:0] w;
        int off;
        w = '0;
        if (v) sq.push_back(d & ((1 << IN_W) - 1));
        if (sq.size() == RATIO || (f && sq.size() > 0)) begin
            while (sq.size() < RATIO) sq.push_back(PADV);
            for (int k = 0; k < RATIO; k++) begin
                off = LSB_FIRST ? k * IN_W : (RATIO - 1 - k) * IN_W;
                w = w | (W'(sq[k]) << off);
            end
            sq.delete();
            if (mq.size() < DEPTH) mq.push_back(w);
            else mdrop++;
        end
    endtask

    task automatic step(input bit v, input int d, input bit f, input bit r);
        bus.in_val  = v;
        bus.in_data = IN_W'(d);
        bus.flush   = f;
        bus.rd_en   = r;
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
        bus.flush  = 1'b0;
        bus.rd_en  = 1'b0;
        m_cycle(v, d, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rd_chk(input string tag);
        logic [W-1:0] exp;
        exp = (mq.size() > 0) ? mq.pop_front() : 'x;
        step(1'b0, 0, 1'b0, 1'b1);
        chk({tag, "_val"}, 64'(bus.dout_val), 64'd1);
        chk(tag, 64'(bus.dout), 64'(exp));
        last_rd = exp;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < RATIO; k++) step(1'b1, int'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.in_val = 1'b0;
        bus.flush  = 1'b0;
        bus.rd_en  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        sq.delete();
        mdrop = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_data = '0;
        bus.in_val  = 1'b0;
        bus.flush   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.hi_mark = (AW+1)'(DEPTH);
        bus.lo_mark = '0;
        @(posedge clk);
        do_reset();

        // reset state
        chk("rst_dout",       64'(bus.dout),       64'd0);
        chk("rst_dout_val",   64'(bus.dout_val),   64'd0);
        chk("rst_empty",      64'(bus.empty),      64'd1);
        chk("rst_full",       64'(bus.full),       64'd0);
        chk("rst_level",      64'(bus.level),      64'd0);
        chk("rst_prog_full",  64'(bus.prog_full),  64'd0);
        chk("rst_prog_empty", 64'(bus.prog_empty), 64'd1);
        chk("rst_partial",    64'(bus.partial),    64'd0);
        chk("rst_overflow",   64'(bus.overflow),   64'd0);
        chk("rst_underflow",  64'(bus.underflow),  64'd0);
        chk("rst_drop_cnt",   64'(bus.drop_cnt),   64'd0);

        // 1: samples 1..8 -> two words; empty falls one edge after sample 4
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
        chk("t1_empty_n", 64'(bus.empty), 64'd1);
        step(1'b1, 5, 1'b0, 1'b0);
        chk("t1_empty_n1", 64'(bus.empty), 64'd0);
        chk("t1_level_n1", 64'(bus.level), 64'd1);
        for (int i = 6; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
        idle(2);
        rd_chk("t1_w0");
        chk("t1_w0_lit", 64'(bus.dout), 64'({6'd4, 6'd3, 6'd2, 6'd1}));
        rd_chk("t1_w1");
        chk("t1_w1_lit", 64'(bus.dout), 64'({6'd8, 6'd7, 6'd6, 6'd5}));

        // 2: partial word + flush, then a no-op flush
        for (int i = 9; i <= 11; i++) step(1'b1, i, 1'b0, 1'b0);
        chk("t2_partial_pre", 64'(bus.partial), 64'd1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t2_partial_post", 64'(bus.partial), 64'd0);
        step(1'b0, 0, 1'b1, 1'b0);
        idle(2);
        chk("t2_level", 64'(bus.level), 64'(mq.size()));
        rd_chk("t2_w");
        chk("t2_w_lit", 64'(bus.dout), 64'({6'd0, 6'd11, 6'd10, 6'd9}));
        chk("t2_empty", 64'(bus.empty), 64'd1);

        // 4: watermarks
        bus.hi_mark = 7'd16;
        bus.lo_mark = 7'd4;
        push_words(16);
        idle(1);
        chk("t4_level16", 64'(bus.level), 64'd16);
        chk("t4_pf_lag", 64'(bus.prog_full), 64'd0);
        idle(1);
        chk("t4_pf", 64'(bus.prog_full), 64'd1);
        chk("t4_pe_hi", 64'(bus.prog_empty), 64'd0);
        for (int i = 0; i < 12; i++) rd_chk("t4_rd");
        chk("t4_level4", 64'(bus.level), 64'd4);
        chk("t4_pe_lag", 64'(bus.prog_empty), 64'd0);
        idle(1);
        chk("t4_pe", 64'(bus.prog_empty), 64'd1);
        chk("t4_pf_lo", 64'(bus.prog_full), 64'd0);
        while (mq.size() > 0) rd_chk("t4_drain");
        bus.hi_mark = (AW+1)'(DEPTH);
        bus.lo_mark = '0;

        // random samples, gaps and flushes, then drain against the model
        for (int i = 0; i < 160 && mq.size() < DEPTH - 2; i++)
            step(($urandom % 4) != 0, int'($urandom), ($urandom % 12) == 0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        idle(2);
        chk("rnd_level", 64'(bus.level), 64'(mq.size()));
        chk("rnd_partial", 64'(bus.partial), 64'd0);
        while (mq.size() > 0) rd_chk("rnd_rd");
        chk("rnd_empty", 64'(bus.empty), 64'd1);

        // 3: overfill by two words
        push_words(DEPTH + 2);
        idle(2);
        chk("t3_full", 64'(bus.full), 64'd1);
        chk("t3_level", 64'(bus.level), 64'(DEPTH));
        chk("t3_overflow", 64'(bus.overflow), 64'd1);
        chk("t3_drop_cnt", 64'(bus.drop_cnt), 64'(mdrop));
        chk("t3_drop_cnt2", 64'(bus.drop_cnt), 64'd2);
        while (mq.size() > 0) rd_chk("t3_rd");
        chk("t3_empty", 64'(bus.empty), 64'd1);

        // 5: full FIFO, write and read on the same edge
        do_reset();
        push_words(DEPTH);
        idle(2);
        chk("t5_full", 64'(bus.full), 64'd1);
        for (int k = 0; k < RATIO - 1; k++) step(1'b1, int'($urandom), 1'b0, 1'b0);
        last_rd = mq.pop_front();
        step(1'b1, int'($urandom), 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t5_val", 64'(bus.dout_val), 64'd1);
        chk("t5_dout", 64'(bus.dout), 64'(last_rd));
        chk("t5_level", 64'(bus.level), 64'(DEPTH));
        chk("t5_overflow", 64'(bus.overflow), 64'd0);
        chk("t5_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        while (mq.size() > 0) rd_chk("t5_rd");
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t5_uf_val", 64'(bus.dout_val), 64'd0);
        chk("t5_underflow", 64'(bus.underflow), 64'd1);
        chk("t5_dout_hold", 64'(bus.dout), 64'(last_rd));

        // 6: reset mid-frame
        push_words(5);
        step(1'b1, 21, 1'b0, 1'b0);
        step(1'b1, 22, 1'b0, 1'b0);
        idle(2);
        chk("t6_level_pre", 64'(bus.level), 64'd5);
        chk("t6_partial_pre", 64'(bus.partial), 64'd1);
        do_reset();
        chk("t6_level", 64'(bus.level), 64'd0);
        chk("t6_empty", 64'(bus.empty), 64'd1);
        chk("t6_partial", 64'(bus.partial), 64'd0);
        chk("t6_overflow", 64'(bus.overflow), 64'd0);
        chk("t6_underflow", 64'(bus.underflow), 64'd0);
        chk("t6_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("t6_dout", 64'(bus.dout), 64'd0);
        idle(3);
        chk("t6_level_late", 64'(bus.level), 64'd0);
        chk("t6_empty_late", 64'(bus.empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
